// File: rtl/ex_seq_ctrl.sv
// Multi-cycle LEGv8 sequencer: FETCH/DECODE/EXEC/MEM/WB FSM driving the EX controls and
// the memory and writeback enables. Counts retired instructions and faults on illegal opcodes or memory timeouts.
module ex_seq_ctrl #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [10:0]      opcode,
    input  logic             Z,
    input  logic             imem_ack,
    input  logic             dmem_ack,
    output logic             imem_req,
    output logic             dmem_req,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             IRWrite,
    output logic             PCWrite,
    output logic             PCSrc,
    output logic [1:0]       ALUOp,
    output logic             ALUSrc,
    output logic             SregUp,
    output logic             RegWrite,
    output logic             MemtoReg,
    output logic [CNT_W-1:0] retired,
    output logic             fault
);

    typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_FAULT} state_t;
    typedef enum logic [2:0] {C_R, C_LD, C_ST, C_CBZ, C_CBNZ, C_B, C_ILL} cls_t;

    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

    state_t           state, next;
    cls_t             dec_cls, cls_q;
    logic [7:0]       wait_cnt;
    logic [CNT_W-1:0] retired_q;
    logic             fault_q;
    logic             retire;
    logic             waiting;

    always_comb begin
        dec_cls = C_ILL;
        if (opcode == 11'b10001011000 || opcode == 11'b11001011000 ||
            opcode == 11'b10001010000 || opcode == 11'b10101010000)
            dec_cls = C_R;
        else if (opcode == 11'b11111000010)
            dec_cls = C_LD;
        else if (opcode == 11'b11111000000)
            dec_cls = C_ST;
        else if (opcode[10:3] == 8'b10110100)
            dec_cls = C_CBZ;
        else if (opcode[10:3] == 8'b10110101)
            dec_cls = C_CBNZ;
        else if (opcode[10:5] == 6'b000101)
            dec_cls = C_B;
    end

    assign waiting = (state == S_FETCH && !imem_ack) || (state == S_MEM && !dmem_ack);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_FETCH;
            cls_q     <= C_ILL;
            wait_cnt  <= '0;
            retired_q <= '0;
            fault_q   <= 1'b0;
        end else begin
            state <= next;
            if (state == S_DECODE)
                cls_q <= dec_cls;
            if (next != state && (next == S_FETCH || next == S_MEM))
                wait_cnt <= '0;
            else if (waiting)
                wait_cnt <= wait_cnt + 8'd1;
            if (retire)
                retired_q <= retired_q + CNT_W'(1);
            if (next == S_FAULT)
                fault_q <= 1'b1;
        end
    end

    always_comb begin
        next     = state;
        retire   = 1'b0;
        imem_req = 1'b0;
        dmem_req = 1'b0;
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        IRWrite  = 1'b0;
        PCWrite  = 1'b0;
        PCSrc    = 1'b0;
        ALUOp    = 2'b00;
        ALUSrc   = 1'b0;
        SregUp   = 1'b0;
        RegWrite = 1'b0;
        MemtoReg = 1'b0;
        case (state)
            S_FETCH: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    IRWrite = 1'b1;
                    PCWrite = 1'b1;
                    next    = S_DECODE;
                end else if (wait_cnt == WAIT_LAST) begin
                    next = S_FAULT;
                end
            end
            S_DECODE: next = (dec_cls == C_ILL) ? S_FAULT : S_EXEC;
            S_EXEC: begin
                case (cls_q)
                    C_R: begin
                        ALUOp = 2'b10;
                        next  = S_WB;
                    end
                    C_LD, C_ST: begin
                        ALUSrc = 1'b1;
                        next   = S_MEM;
                    end
                    C_CBZ, C_CBNZ: begin
                        ALUOp  = 2'b01;
                        ALUSrc = 1'b1;
                        SregUp = 1'b1;
                        if ((cls_q == C_CBZ && Z) || (cls_q == C_CBNZ && !Z)) begin
                            PCWrite = 1'b1;
                            PCSrc   = 1'b1;
                        end
                        retire = 1'b1;
                        next   = S_FETCH;
                    end
                    C_B: begin
                        ALUOp   = 2'b11;
                        PCWrite = 1'b1;
                        PCSrc   = 1'b1;
                        retire  = 1'b1;
                        next    = S_FETCH;
                    end
                    default: next = S_FAULT;
                endcase
            end
            S_MEM: begin
                dmem_req = 1'b1;
                MemRead  = (cls_q == C_LD);
                MemWrite = (cls_q == C_ST);
                ALUSrc   = 1'b1;
                if (dmem_ack) begin
                    retire = (cls_q != C_LD);
                    next   = (cls_q == C_LD) ? S_WB : S_FETCH;
                end else if (wait_cnt == WAIT_LAST) begin
                    next = S_FAULT;
                end
            end
            S_WB: begin
                RegWrite = 1'b1;
                MemtoReg = (cls_q == C_LD);
                retire   = 1'b1;
                next     = S_FETCH;
            end
            default: next = S_FAULT;
        endcase
        // Reset kills every strobe in the same cycle so an aborted instruction leaves no side effect.
        if (rst) begin
            imem_req = 1'b0;
            dmem_req = 1'b0;
            MemRead  = 1'b0;
            MemWrite = 1'b0;
            IRWrite  = 1'b0;
            PCWrite  = 1'b0;
            PCSrc    = 1'b0;
            ALUOp    = 2'b00;
            ALUSrc   = 1'b0;
            SregUp   = 1'b0;
            RegWrite = 1'b0;
            MemtoReg = 1'b0;
        end
    end

    assign retired = rst ? '0 : retired_q;
    assign fault   = fault_q & ~rst;

endmodule
